rule_max_aggregator: RTL

- Downstream stage of the per-rule min comparator tree (6 antecedents, 7-bit, stall-able pipeline that advances only while start=1).
- Re-aligns the tree's result to its start stream, max-aggregates NUM_RULES rule strengths (Mamdani OR across rules), and hands one aggregated strength per batch to the defuzzifier over a valid/ready handshake.
- Holds a one-entry output buffer and flags batches lost to back-pressure.

---
 rtl/fuzzy_agg_pkg.sv | 13 +
 rtl/valid_align_pipe.sv | 42 ++++
 rtl/rule_max_aggregator.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/fuzzy_agg_pkg.sv
// rtl/fuzzy_agg_pkg.sv - shared types and default sizes for the rule max aggregator
package fuzzy_agg_pkg;
  localparam int DEFAULT_DATA_W    = 7;
  localparam int DEFAULT_LATENCY   = 3;
  localparam int DEFAULT_NUM_RULES = 8;

  typedef logic [DEFAULT_DATA_W-1:0] strength_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } agg_state_e;
endpackage

// File: rtl/valid_align_pipe.sv
// rtl/valid_align_pipe.sv - stall-able tag shift register that marks which start cycles carry a valid tree result
module valid_align_pipe #(
  parameter int LATENCY = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic in_start,
  input  logic clear,
  output logic valid,
  output logic any_set
);
  logic [LATENCY-1:0] tag_q, tag_d, tag_shift;

  // The pipe view after this start's shift: priming lasts LATENCY-1 start cycles.
  generate
    if (LATENCY == 1) begin : g_single
      assign tag_shift = 1'b1;
    end else begin : g_multi
      assign tag_shift = {tag_q[LATENCY-2:0], 1'b1};
    end
  endgenerate

  always_comb begin
    tag_d = tag_q;
    if (clear) begin
      tag_d = '0;
    end else if (in_start) begin
      tag_d = tag_shift;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign valid   = in_start && !clear && tag_shift[LATENCY-1];
  assign any_set = |tag_q;
endmodule

// File: rtl/rule_max_aggregator.sv
// rtl/rule_max_aggregator.sv - max-aggregates NUM_RULES rule strengths into a one-entry output buffer
// Optional winning-rule index output: define RULE_MAX_AGGREGATOR_ARGMAX_EN.
module rule_max_aggregator
  import fuzzy_agg_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int LATENCY   = DEFAULT_LATENCY,
  parameter int NUM_RULES = DEFAULT_NUM_RULES,
  localparam int IDX_W    = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_start,
  input  logic [DATA_W-1:0] in_result,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
`ifdef RULE_MAX_AGGREGATOR_ARGMAX_EN
  output logic [IDX_W-1:0]  out_index,
`endif
  output logic              overflow,
  output logic              busy
);
  localparam int CNT_W = $clog2(NUM_RULES + 1);

  agg_state_e        state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d, cand;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              overflow_q, overflow_d;
  logic              rule_valid, tag_any, take_new, last, complete, accept;

  valid_align_pipe #(.LATENCY(LATENCY)) u_align (
    .clock    (clock),
    .reset    (reset),
    .in_start (in_start),
    .clear    (clear),
    .valid    (rule_valid),
    .any_set  (tag_any)
  );

  // Strict > so a tie keeps the earlier rule's strength (and index).
  assign take_new = (state_q == IDLE) || (in_result > acc_q);
  assign cand     = take_new ? in_result : acc_q;
  assign last     = (cnt_q == CNT_W'(NUM_RULES - 1));
  assign complete = rule_valid && last;
  assign accept   = complete && (!out_valid_q || out_ready);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    overflow_d  = overflow_q;

    if (rule_valid) begin
      if (last) begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
      end else begin
        state_d = ACCUM;
        acc_d   = cand;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = cand;
    end else if (complete) begin
      overflow_d = 1'b1;
    end

    if (clear) begin
      state_d    = IDLE;
      acc_d      = '0;
      cnt_d      = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef RULE_MAX_AGGREGATOR_ARGMAX_EN
  logic [IDX_W-1:0] idx_q, idx_d, out_idx_q, out_idx_d, cand_idx;

  assign cand_idx = take_new ? IDX_W'(cnt_q) : idx_q;

  always_comb begin
    idx_d     = idx_q;
    out_idx_d = out_idx_q;
    if (rule_valid) begin
      idx_d = last ? '0 : cand_idx;
    end
    if (accept) begin
      out_idx_d = cand_idx;
    end
    if (clear) begin
      idx_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_q     <= '0;
      out_idx_q <= '0;
    end else begin
      idx_q     <= idx_d;
      out_idx_q <= out_idx_d;
    end
  end

  assign out_index = out_idx_q;
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q == ACCUM) || tag_any;
endmodule
